// File: rtl/spi_target_ep.sv
// SPI mode-3 target endpoint: oversamples CS/SCK/MOSI on clk, deserialises
// received bytes and serialises bytes from a one-entry holding register.
module spi_target_ep #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_cs_b,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_first,
  input  logic [7:0]  tx_data,
  input  logic        tx_put,
  output logic        tx_free,
  output logic        xfr_active,
  output logic        xfr_end,
  output logic        xfr_partial,
  output logic [15:0] byte_count,
  output logic        err_underrun,
  output logic        err_tx_drop,
  input  logic        err_clear
);

  localparam logic [1:0] ST_WAIT_DESELECT = 2'd0;
  localparam logic [1:0] ST_IDLE          = 2'd1;
  localparam logic [1:0] ST_ACTIVE        = 2'd2;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_cs_dly;
  logic                   r_sck_dly;
  logic [SYNC_STAGES:0]   r_flush;

  logic [1:0]  r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_first;
  logic        r_first;
  logic [15:0] r_byte_count;
  logic [7:0]  r_tx_shift;
  logic        r_miso;
  logic        r_xfr_end;
  logic        r_xfr_partial;
  logic [7:0]  r_hold;
  logic        r_tx_free;
  logic        r_err_underrun;
  logic        r_err_tx_drop;

  logic       w_cs;
  logic       w_sck;
  logic       w_mosi;
  logic       w_cs_rise;
  logic       w_cs_fall;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_active;
  logic       w_fall_act;
  logic       w_rise_act;
  logic       w_load;
  logic       w_load_hold;
  logic       w_load_bypass;
  logic       w_load_fill;
  logic [7:0] w_load_byte;
  logic       w_sync_ready;

  // Input synchronisers plus one delay stage on CS/SCK for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_sync   <= '1;
      r_sck_sync  <= '1;
      r_mosi_sync <= '0;
      r_cs_dly    <= 1'b1;
      r_sck_dly   <= 1'b1;
      r_flush     <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_b};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_dly    <= r_cs_sync[SYNC_STAGES-1];
      r_sck_dly   <= r_sck_sync[SYNC_STAGES-1];
      r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_rise  = w_cs & ~r_cs_dly;
  assign w_cs_fall  = ~w_cs & r_cs_dly;
  assign w_sck_rise = w_sck & ~r_sck_dly;
  assign w_sck_fall = ~w_sck & r_sck_dly;

  // The synchronisers reset to "deselected", so CS is only trusted once the
  // chain has refilled from the pin; otherwise a reset with CS held low would
  // leave WAIT_DESELECT immediately and decode the tail of the old frame.
  assign w_sync_ready = r_flush[SYNC_STAGES];

  assign w_active      = (r_state == ST_ACTIVE);
  assign w_fall_act    = w_active & ~w_cs_rise & w_sck_fall;
  assign w_rise_act    = w_active & ~w_cs_rise & w_sck_rise;
  assign w_load        = w_fall_act & (r_bit_cnt == 3'd0);
  assign w_load_hold   = w_load & ~r_tx_free;
  assign w_load_bypass = w_load & r_tx_free & tx_put;
  assign w_load_fill   = w_load & r_tx_free & ~tx_put;
  assign w_load_byte   = !r_tx_free ? r_hold : (tx_put ? tx_data : FILL_BYTE);

  // Transfer FSM, receive deserialiser and transmit serialiser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_WAIT_DESELECT;
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_first    <= 1'b0;
      r_first       <= 1'b0;
      r_byte_count  <= '0;
      r_tx_shift    <= '0;
      r_miso        <= 1'b1;
      r_xfr_end     <= 1'b0;
      r_xfr_partial <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_xfr_end  <= 1'b0;
      case (r_state)
        ST_WAIT_DESELECT: begin
          r_miso <= 1'b1;
          if (w_sync_ready && w_cs) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          r_miso <= 1'b1;
          if (w_cs_fall) begin
            r_state      <= ST_ACTIVE;
            r_bit_cnt    <= '0;
            r_byte_count <= '0;
            r_first      <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state       <= ST_IDLE;
            r_xfr_end     <= 1'b1;
            r_xfr_partial <= (r_bit_cnt != 3'd0);
            r_bit_cnt     <= '0;
            r_miso        <= 1'b1;
          end else begin
            if (w_sck_fall) begin
              if (r_bit_cnt == 3'd0) begin
                r_tx_shift <= w_load_byte;
                r_miso     <= w_load_byte[7];
              end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                r_miso     <= r_tx_shift[6];
              end
            end
            if (w_sck_rise) begin
              r_rx_shift <= {r_rx_shift[6:0], w_mosi};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_rx_data  <= {r_rx_shift[6:0], w_mosi};
                r_rx_valid <= 1'b1;
                r_rx_first <= r_first;
                r_first    <= 1'b0;
                if (r_byte_count != 16'hFFFF) r_byte_count <= r_byte_count + 16'd1;
              end
            end
          end
        end
        default: r_state <= ST_WAIT_DESELECT;
      endcase
    end
  end

  // Transmit holding register: filled by tx_put, emptied by a falling-edge load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold    <= '0;
      r_tx_free <= 1'b1;
    end else begin
      if (w_load_hold) begin
        r_tx_free <= 1'b1;
      end else if (tx_put && r_tx_free && !w_load_bypass) begin
        r_hold    <= tx_data;
        r_tx_free <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new set event wins over err_clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_underrun <= 1'b0;
      r_err_tx_drop  <= 1'b0;
    end else begin
      if (w_load_fill)    r_err_underrun <= 1'b1;
      else if (err_clear) r_err_underrun <= 1'b0;
      if (tx_put && !r_tx_free) r_err_tx_drop <= 1'b1;
      else if (err_clear)       r_err_tx_drop <= 1'b0;
    end
  end

  assign spi_miso     = r_miso;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_first     = r_rx_first;
  assign tx_free      = r_tx_free;
  assign xfr_active   = w_active;
  assign xfr_end      = r_xfr_end;
  assign xfr_partial  = r_xfr_partial;
  assign byte_count   = r_byte_count;
  assign err_underrun = r_err_underrun;
  assign err_tx_drop  = r_err_tx_drop;

endmodule

// File: tb/tb_spi_target_ep.sv
// Directed bench for spi_target_ep: bit-banged SPI mode-3 master, scoreboard
// queues for received bytes and deselect events.
module tb_spi_target_ep;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs_b = 1'b1;
  logic        sck = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_first;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_put = 1'b0;
  logic        tx_free;
  logic        xfr_active;
  logic        xfr_end;
  logic        xfr_partial;
  logic [15:0] byte_count;
  logic        err_underrun;
  logic        err_tx_drop;
  logic        err_clear = 1'b0;

  int n_err = 0;
  int n_chk = 0;

  logic [8:0] rx_q[$];
  logic       xfr_q[$];
  bit         xfr_ignore = 1'b0;
  logic [8:0] mon_rx;
  logic       mon_x;
  logic [7:0] got;

  spi_target_ep #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .spi_cs_b(cs_b), .spi_sck(sck), .spi_mosi(mosi),
    .spi_miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_data(tx_data), .tx_put(tx_put), .tx_free(tx_free), .xfr_active(xfr_active),
    .xfr_end(xfr_end), .xfr_partial(xfr_partial), .byte_count(byte_count),
    .err_underrun(err_underrun), .err_tx_drop(err_tx_drop), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Shift nbits MSB-first; optionally pulse tx_put(8'h55) in the load cycle
  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit put55,
                          output logic [7:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = b[7-i];
      for (int k = 0; k < HALF; k++) begin
        @(posedge clk);
        #1;
        if (put55 && i == 0 && k == 1) begin
          tx_data = 8'h55;
          tx_put  = 1'b1;
        end
        if (put55 && i == 0 && k == 2) tx_put = 1'b0;
      end
      rd  = {rd[6:0], miso};
      sck = 1'b1;
      cyc(HALF);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first, input logic [7:0] exp_miso,
                           input string tag);
    logic [7:0] rd;
    rx_q.push_back({first, b});
    spi_bits(b, 8, 1'b0, rd);
    check(tag, rd, exp_miso);
  endtask

  task automatic do_select();
    cs_b = 1'b0;
    cyc(HALF);
  endtask

  task automatic do_deselect(input logic partial);
    xfr_q.push_back(partial);
    cs_b = 1'b1;
    cyc(HALF + 2);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
  endtask

  // Output monitor: every rx_valid / xfr_end must match a scoreboard entry
  always @(negedge clk) begin
    if (reset_n && rx_valid) begin
      check("rx_expected", rx_q.size() != 0, 1);
      if (rx_q.size() != 0) begin
        mon_rx = rx_q.pop_front();
        check("rx_data", rx_data, mon_rx[7:0]);
        check("rx_first", rx_first, mon_rx[8]);
      end
    end
    if (reset_n && xfr_end && !xfr_ignore) begin
      check("xfr_expected", xfr_q.size() != 0, 1);
      if (xfr_q.size() != 0) begin
        mon_x = xfr_q.pop_front();
        check("xfr_partial", xfr_partial, mon_x);
      end
    end
  end

  initial begin
    // Reset values
    cyc(3);
    check("rst_miso", miso, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_first", rx_first, 0);
    check("rst_tx_free", tx_free, 1);
    check("rst_active", xfr_active, 0);
    check("rst_xfr_end", xfr_end, 0);
    check("rst_partial", xfr_partial, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_underrun", err_underrun, 0);
    check("rst_tx_drop", err_tx_drop, 0);
    reset_n = 1'b1;
    cyc(10);

    // Single byte with preloaded transmit byte
    tx_data = 8'hA5;
    tx_put  = 1'b1;
    cyc(1);
    tx_put  = 1'b0;
    check("t1_tx_free_busy", tx_free, 0);
    do_select();
    check("t1_active", xfr_active, 1);
    send_byte(8'h3C, 1'b1, 8'hA5, "t1_miso");
    check("t1_byte_count", byte_count, 1);
    check("t1_tx_free_back", tx_free, 1);
    do_deselect(1'b0);
    check("t1_inactive", xfr_active, 0);

    // Three bytes, one transmit byte then underrun
    tx_data = 8'h11;
    tx_put  = 1'b1;
    cyc(1);
    tx_put  = 1'b0;
    do_select();
    send_byte(8'h01, 1'b1, 8'h11, "t2_miso0");
    send_byte(8'h02, 1'b0, 8'hFF, "t2_miso1");
    send_byte(8'h03, 1'b0, 8'hFF, "t2_miso2");
    check("t2_byte_count", byte_count, 3);
    do_deselect(1'b0);
    check("t2_underrun", err_underrun, 1);
    pulse_clear();
    check("t2_underrun_clr", err_underrun, 0);

    // tx_put exactly in the load cycle bypasses the empty holding register
    do_select();
    rx_q.push_back({1'b1, 8'h77});
    spi_bits(8'h77, 8, 1'b1, got);
    check("t3_miso", got, 8'h55);
    check("t3_underrun", err_underrun, 0);
    check("t3_tx_free", tx_free, 1);
    do_deselect(1'b0);

    // Partial byte then a clean frame
    do_select();
    spi_bits(8'hA8, 5, 1'b0, got);
    do_deselect(1'b1);
    do_select();
    send_byte(8'hC3, 1'b1, 8'hFF, "t4_miso");
    do_deselect(1'b0);
    check("t4_byte_count", byte_count, 1);
    pulse_clear();

    // Reset mid-byte with CS held low; tail bits must not decode
    do_select();
    spi_bits(8'hE0, 3, 1'b0, got);
    reset_n = 1'b0;
    cyc(2);
    check("t5_rst_miso", miso, 1);
    check("t5_rst_active", xfr_active, 0);
    xfr_ignore = 1'b1;
    reset_n = 1'b1;
    spi_bits(8'hF0, 4, 1'b0, got);
    cs_b = 1'b1;
    cyc(HALF + 2);
    check("t5_inactive", xfr_active, 0);
    xfr_ignore = 1'b0;
    do_select();
    send_byte(8'h9A, 1'b1, 8'hFF, "t5_miso");
    do_deselect(1'b0);
    check("t5_rx_data", rx_data, 8'h9A);
    check("t5_byte_count", byte_count, 1);
    pulse_clear();

    // Back-to-back tx_put: first accepted, second dropped
    tx_data = 8'h55;
    tx_put  = 1'b1;
    cyc(1);
    tx_data = 8'hAA;
    cyc(1);
    tx_put  = 1'b0;
    cyc(1);
    check("t6_tx_drop", err_tx_drop, 1);
    check("t6_tx_free", tx_free, 0);
    pulse_clear();
    check("t6_tx_drop_clr", err_tx_drop, 0);
    do_select();
    send_byte(8'h5A, 1'b1, 8'h55, "t6_miso");
    do_deselect(1'b0);

    cyc(4);
    check("rx_q_drained", rx_q.size(), 0);
    check("xfr_q_drained", xfr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
